// File: rtl/falafel_output_arb_if.sv
// Response channel bundle for the falafel output arbiter.
// Carries the registered response word, its source tag and the handshake.
interface falafel_output_arb_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic              val;
    logic              rdy;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;

    modport master (
        output val,
        output data,
        output ch,
        input  rdy
    );

    modport slave (
        input  val,
        input  data,
        input  ch,
        output rdy
    );
endinterface

// File: rtl/falafel_output_arb.sv
// falafel allocator response output stage: round-robin drain of the
// per-channel response FIFOs into a registered main+skid output buffer.
package falafel_pkg;
    localparam int DATA_W = 32;
endpackage

module falafel_output_arb #(
    parameter int DATA_W = falafel_pkg::DATA_W,
    parameter int NUM_CH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    falafel_output_arb_if.master     rsp,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic [NUM_CH-1:0]        resp_fifo_empty_i,
    output logic [NUM_CH-1:0]        resp_fifo_read_o,
    input  logic [NUM_CH*DATA_W-1:0] resp_fifo_dout_i,
    output logic [1:0]               occ_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   ptr_nxt;
    logic [CH_W:0]     sum;
    logic [NUM_CH-1:0] elig;
    logic              found;
    logic              push;
    logic              take;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CH_W-1:0]   main_ch;
    logic [CH_W-1:0]   skid_ch;

    assign elig = ~resp_fifo_empty_i & ch_en_i;

    // Rotating priority scan starting at ptr, wrapping at NUM_CH.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH))
                sum = sum - (CH_W+1)'(NUM_CH);
            if (!found && elig[sum[CH_W-1:0]]) begin
                found = 1'b1;
                grant = sum[CH_W-1:0];
            end
        end
    end

    // Only the granted head is ever routed, so idle FIFO X never leaks.
    always_comb begin
        head = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CH_W'(c))
                head = resp_fifo_dout_i[c*DATA_W +: DATA_W];
        end
    end

    assign push = found && (state != FULL) && !rst_i;
    assign take = (state != EMPTY) && rsp.rdy;

    always_comb begin
        resp_fifo_read_o = '0;
        if (push)
            resp_fifo_read_o[grant] = 1'b1;
    end

    assign ptr_nxt = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            ptr       <= '0;
            main_data <= '0;
            main_ch   <= '0;
            skid_data <= '0;
            skid_ch   <= '0;
        end else begin
            if (push)
                ptr <= ptr_nxt;
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state     <= ONE;
                        main_data <= head;
                        main_ch   <= grant;
                    end
                end
                ONE: begin
                    if (push && take) begin
                        main_data <= head;
                        main_ch   <= grant;
                    end else if (push) begin
                        state     <= FULL;
                        skid_data <= head;
                        skid_ch   <= grant;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        main_ch   <= skid_ch;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign rsp.val  = (state != EMPTY);
    assign rsp.data = main_data;
    assign rsp.ch   = main_ch;
    assign occ_o    = state;
endmodule

// File: tb/tb_falafel_output_arb.sv
// Directed bench for falafel_output_arb: 4-channel build plus a 1-channel
// build driven by random traffic against a scoreboard.
module tb_falafel_output_arb;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    // ---------------- 4-channel DUT and FIFO model ----------------
    falafel_output_arb_if #(.DATA_W(DW), .CH_W(2)) rif4 ();
    logic [3:0]      en4;
    logic [3:0]      emp4;
    logic [3:0]      rd4;
    logic [3:0]      ld4;
    logic [DW-1:0]   ld4_d [4];
    logic [4*DW-1:0] dout4;
    logic [1:0]      occ4;
    logic [DW-1:0]   m4 [4][64];
    int              h4 [4];
    int              t4 [4];
    int              bad4 = 0;

    falafel_output_arb #(.DATA_W(DW), .NUM_CH(4)) u4 (
        .clk_i             (clk),
        .rst_i             (rst),
        .rsp               (rif4),
        .ch_en_i           (en4),
        .resp_fifo_empty_i (emp4),
        .resp_fifo_read_o  (rd4),
        .resp_fifo_dout_i  (dout4),
        .occ_o             (occ4)
    );

    initial begin
        for (int c = 0; c < 4; c++) begin
            h4[c] = 0;
            t4[c] = 0;
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (rd4[c]) begin
                if (h4[c] == t4[c]) bad4 <= bad4 + 1;
                else h4[c] <= h4[c] + 1;
            end
            if (ld4[c]) begin
                m4[c][t4[c][5:0]] <= ld4_d[c];
                t4[c] <= t4[c] + 1;
            end
        end
        if (!$onehot0(rd4)) bad4 <= bad4 + 1;
    end

    always_comb begin
        emp4  = '0;
        dout4 = '0;
        for (int c = 0; c < 4; c++) begin
            emp4[c] = (h4[c] == t4[c]);
            dout4[c*DW +: DW] = emp4[c] ? {DW{1'bx}} : m4[c][h4[c][5:0]];
        end
    end

    // ---------------- 1-channel DUT and FIFO model ----------------
    falafel_output_arb_if #(.DATA_W(DW), .CH_W(1)) rif1 ();
    logic          en1 = 1'b1;
    logic          emp1;
    logic          rd1;
    logic          ld1;
    logic [DW-1:0] ld1_d;
    logic [DW-1:0] dout1;
    logic [1:0]    occ1;
    logic [DW-1:0] m1 [64];
    int            h1 = 0;
    int            t1 = 0;
    int            bad1 = 0;

    falafel_output_arb #(.DATA_W(DW), .NUM_CH(1)) u1 (
        .clk_i             (clk),
        .rst_i             (rst),
        .rsp               (rif1),
        .ch_en_i           (en1),
        .resp_fifo_empty_i (emp1),
        .resp_fifo_read_o  (rd1),
        .resp_fifo_dout_i  (dout1),
        .occ_o             (occ1)
    );

    always @(posedge clk) begin
        if (rd1) begin
            if (h1 == t1) bad1 <= bad1 + 1;
            else h1 <= h1 + 1;
        end
        if (ld1) begin
            m1[t1[5:0]] <= ld1_d;
            t1 <= t1 + 1;
        end
    end

    always_comb begin
        emp1  = (h1 == t1);
        dout1 = emp1 ? {DW{1'bx}} : m1[h1[5:0]];
    end

    // ---------------- helpers (no checking) ----------------
    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        ld4      = '0;
        ld1      = 1'b0;
        en4      = '0;
        rif4.rdy = 1'b0;
        rif1.rdy = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic load4(input logic [3:0] m, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [DW-1:0] d3);
        ld4      = m;
        ld4_d[0] = d0;
        ld4_d[1] = d1;
        ld4_d[2] = d2;
        ld4_d[3] = d3;
        step;
        ld4 = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        en4      = 4'hF;
        rif4.rdy = 1'b1;
        rif1.rdy = 1'b0;
        ld1      = 1'b0;
        ld4      = 4'b0010;
        ld4_d[1] = 16'h5A5A;
        step;
        ld4 = '0;
        step;
        vec++; if (rif4.val !== 1'b0) begin miss++; $display("FAIL reset_val got %b want 0", rif4.val); end
        vec++; if (occ4 !== 2'd0) begin miss++; $display("FAIL reset_occ got %0d want 0", occ4); end
        vec++; if (rif4.data !== 16'h0) begin miss++; $display("FAIL reset_data got %h want 0", rif4.data); end
        vec++; if (rif4.ch !== 2'd0) begin miss++; $display("FAIL reset_ch got %0d want 0", rif4.ch); end
        vec++; if (rd4 !== 4'b0) begin miss++; $display("FAIL reset_pop got %b want 0000", rd4); end
        vec++; if (rif1.val !== 1'b0) begin miss++; $display("FAIL reset_val1 got %b want 0", rif1.val); end
        rst = 1'b0;
        #1;
        vec++; if (rd4 !== 4'b0010) begin miss++; $display("FAIL reset_first_pop got %b want 0010", rd4); end
        step;
        vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h5A5A || rif4.ch !== 2'd1) begin
            miss++; $display("FAIL reset_after got v%b %h ch%0d want v1 5a5a ch1", rif4.val, rif4.data, rif4.ch);
        end
        step;
        vec++; if (rif4.val !== 1'b0) begin miss++; $display("FAIL reset_drain got %b want 0", rif4.val); end
    endtask

    task automatic test_single;
        logic [DW-1:0] w [3];
        w[0] = 16'h00A1;
        w[1] = 16'h00A2;
        w[2] = 16'h00A3;
        do_reset;
        en4      = 4'b0001;
        rif4.rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld4 = (i < 3) ? 4'b0001 : 4'b0000;
            if (i < 3) ld4_d[0] = w[i];
            step;
            if (i == 0) begin
                vec++; if (rd4 !== 4'b0001) begin miss++; $display("FAIL single_pop got %b want 0001", rd4); end
            end
            if (i == 0 || i == 4) begin
                vec++; if (rif4.val !== 1'b0) begin miss++; $display("FAIL single_idle%0d got %b want 0", i, rif4.val); end
            end else begin
                vec++; if (rif4.val !== 1'b1 || rif4.data !== w[i-1] || rif4.ch !== 2'd0) begin
                    miss++; $display("FAIL single_out%0d got v%b %h ch%0d want v1 %h ch0", i, rif4.val, rif4.data, rif4.ch, w[i-1]);
                end
            end
            vec++; if (occ4 > 2'd1) begin miss++; $display("FAIL single_occ got %0d want <=1", occ4); end
        end
        ld4 = '0;
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] e;
        do_reset;
        load4(4'hF, 16'hC001, 16'hC011, 16'hC021, 16'hC031);
        load4(4'hF, 16'hC002, 16'hC012, 16'hC022, 16'hC032);
        en4      = 4'hF;
        rif4.rdy = 1'b1;
        step;
        for (int j = 0; j < 8; j++) begin
            e = 16'hC000 + 16'((j % 4) * 16 + j / 4 + 1);
            vec++; if (rif4.val !== 1'b1 || rif4.ch !== 2'(j % 4) || rif4.data !== e) begin
                miss++; $display("FAIL rr_out%0d got v%b ch%0d %h want v1 ch%0d %h", j, rif4.val, rif4.ch, rif4.data, j % 4, e);
            end
            step;
        end
        vec++; if (rif4.val !== 1'b0 || emp4 !== 4'hF) begin
            miss++; $display("FAIL rr_end got v%b emp%b want v0 emp1111", rif4.val, emp4);
        end
    endtask

    task automatic test_backpressure;
        int pops;
        pops = 0;
        do_reset;
        load4(4'b0010, 16'h0, 16'h0011, 16'h0, 16'h0);
        load4(4'b0010, 16'h0, 16'h0012, 16'h0, 16'h0);
        load4(4'b0010, 16'h0, 16'h0013, 16'h0, 16'h0);
        en4      = 4'b0010;
        rif4.rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rd4[1]) pops++;
            if (k >= 1) begin
                vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h0011) begin
                    miss++; $display("FAIL bp_stall%0d got v%b %h want v1 0011", k, rif4.val, rif4.data);
                end
            end
            step;
        end
        vec++; if (pops !== 2) begin miss++; $display("FAIL bp_pops got %0d want 2", pops); end
        vec++; if (occ4 !== 2'd2) begin miss++; $display("FAIL bp_occ got %0d want 2", occ4); end
        vec++; if (rif4.data !== 16'h0011) begin miss++; $display("FAIL bp_hold got %h want 0011", rif4.data); end
        rif4.rdy = 1'b1;
        step;
        vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h0012) begin
            miss++; $display("FAIL bp_rel1 got v%b %h want v1 0012", rif4.val, rif4.data);
        end
        step;
        vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h0013) begin
            miss++; $display("FAIL bp_rel2 got v%b %h want v1 0013", rif4.val, rif4.data);
        end
        step;
        vec++; if (rif4.val !== 1'b0 || emp4[1] !== 1'b1 || bad4 !== 0) begin
            miss++; $display("FAIL bp_end got v%b emp%b bad%0d want v0 emp1 bad0", rif4.val, emp4[1], bad4);
        end
    endtask

    task automatic test_mask;
        int chs [12];
        int wds [12];
        logic [DW-1:0] e;
        chs = '{0, 2, 0, 2, 3, 0, 1, 2, 3, 1, 3, 1};
        wds = '{1, 1, 2, 2, 1, 3, 1, 3, 2, 2, 3, 3};
        do_reset;
        for (int k = 1; k <= 3; k++)
            load4(4'hF, 16'hD000 + 16'(k), 16'hD010 + 16'(k),
                  16'hD020 + 16'(k), 16'hD030 + 16'(k));
        en4      = 4'b0101;
        rif4.rdy = 1'b1;
        step;
        for (int j = 0; j < 12; j++) begin
            e = 16'hD000 + 16'(chs[j] * 16 + wds[j]);
            vec++; if (rif4.val !== 1'b1 || rif4.ch !== 2'(chs[j]) || rif4.data !== e) begin
                miss++; $display("FAIL mask_out%0d got v%b ch%0d %h want v1 ch%0d %h", j, rif4.val, rif4.ch, rif4.data, chs[j], e);
            end
            if (j == 3) en4 = 4'hF;
            step;
        end
        vec++; if (rif4.val !== 1'b0 || emp4 !== 4'hF) begin
            miss++; $display("FAIL mask_end got v%b emp%b want v0 emp1111", rif4.val, emp4);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        load4(4'b0100, 16'h0, 16'h0, 16'h00E1, 16'h0);
        load4(4'b0100, 16'h0, 16'h0, 16'h00E2, 16'h0);
        load4(4'b0101, 16'h00F0, 16'h0, 16'h00E3, 16'h0);
        en4      = 4'b0100;
        rif4.rdy = 1'b0;
        step;
        step;
        vec++; if (occ4 !== 2'd2 || emp4[2] !== 1'b0) begin
            miss++; $display("FAIL rmid_pre got occ%0d emp%b want occ2 emp0", occ4, emp4[2]);
        end
        rst = 1'b1;
        #1;
        vec++; if (rd4 !== 4'b0) begin miss++; $display("FAIL rmid_pop got %b want 0000", rd4); end
        step;
        vec++; if (rif4.val !== 1'b0 || occ4 !== 2'd0 || rif4.data !== 16'h0) begin
            miss++; $display("FAIL rmid_rst got v%b occ%0d %h want v0 occ0 0000", rif4.val, occ4, rif4.data);
        end
        rst      = 1'b0;
        en4      = 4'b0101;
        rif4.rdy = 1'b1;
        #1;
        vec++; if (rd4 !== 4'b0001) begin miss++; $display("FAIL rmid_scan got %b want 0001", rd4); end
        step;
        vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h00F0 || rif4.ch !== 2'd0) begin
            miss++; $display("FAIL rmid_out0 got v%b %h ch%0d want v1 00f0 ch0", rif4.val, rif4.data, rif4.ch);
        end
        step;
        vec++; if (rif4.val !== 1'b1 || rif4.data !== 16'h00E3 || rif4.ch !== 2'd2) begin
            miss++; $display("FAIL rmid_out1 got v%b %h ch%0d want v1 00e3 ch2", rif4.val, rif4.data, rif4.ch);
        end
        step;
        vec++; if (rif4.val !== 1'b0 || emp4 !== 4'hF || bad4 !== 0) begin
            miss++; $display("FAIL rmid_end got v%b emp%b bad%0d want v0 emp1111 bad0", rif4.val, emp4, bad4);
        end
    endtask

    task automatic test_single_ch;
        logic [DW-1:0] sb [$];
        logic [DW-1:0] nxt;
        logic [DW-1:0] e;
        nxt = 16'h1000;
        do_reset;
        for (int i = 0; i < 1040; i++) begin
            ld1 = (i < 1000) && ($urandom_range(0, 2) != 0) && (t1 - h1 < 32);
            if (ld1) begin
                ld1_d = nxt;
                sb.push_back(nxt);
                nxt++;
            end
            rif1.rdy = (i >= 1000) || ($urandom_range(0, 1) != 0);
            #1;
            vec++; if (rd1 && (emp1 || occ1 == 2'd2)) begin
                miss++; $display("FAIL one_pop%0d got rd1 emp%b occ%0d want no pop", i, emp1, occ1);
            end
            if (rif1.val && rif1.rdy) begin
                if (sb.size() == 0) begin
                    vec++; miss++; $display("FAIL one_extra%0d got %h want none", i, rif1.data);
                end else begin
                    e = sb.pop_front();
                    vec++; if (rif1.data !== e || rif1.ch !== 1'b0) begin
                        miss++; $display("FAIL one_data%0d got %h ch%0d want %h ch0", i, rif1.data, rif1.ch, e);
                    end
                end
            end
            step;
        end
        ld1 = 1'b0;
        vec++; if (sb.size() != 0 || rif1.val !== 1'b0 || bad1 !== 0) begin
            miss++; $display("FAIL one_end got left%0d v%b bad%0d want 0 v0 0", sb.size(), rif1.val, bad1);
        end
    endtask

    initial begin
        en4      = '0;
        ld4      = '0;
        ld1      = 1'b0;
        ld1_d    = '0;
        rif4.rdy = 1'b0;
        rif1.rdy = 1'b0;
        for (int c = 0; c < 4; c++) ld4_d[c] = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_mask;
        test_reset_mid;
        test_single_ch;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/falafel_output_arb.md
Name: falafel_output_arb

Overview:
- Multi-channel response output stage for the falafel allocator.
- Drains NUM_CH first-word-fall-through response FIFOs onto a single response channel, using round-robin arbitration and a per-channel enable mask.
- Registered 2-entry output buffer (main + skid):
  - no combinational path from rsp_rdy_i to any resp_fifo_read_o;
  - sustains 1 response/cycle;
  - tags each response with its source channel.
- Sits between the per-channel response FIFOs and the external response interface.

Parameters:
- DATA_W, default falafel_pkg::DATA_W: response word width.
- NUM_CH, default 4: number of response FIFOs/channels, legal range 1..16.
- CH_W, default $clog2(NUM_CH) (minimum 1): width of the channel tag; derived, not overridden.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rsp_rdy_i  in  1  downstream ready.
- rsp_val_o  out  1  response valid.
- rsp_data_o  out  DATA_W  response word.
- rsp_ch_o  out  CH_W  source channel of rsp_data_o.
- ch_en_i  in  NUM_CH  per-channel arbitration enable.
- resp_fifo_empty_i  in  NUM_CH  per-FIFO empty flag.
- resp_fifo_read_o  out  NUM_CH  per-FIFO pop; one-hot or zero.
- resp_fifo_dout_i  in  NUM_CH*DATA_W  FIFO heads; channel c occupies bits [c*DATA_W +: DATA_W].
- occ_o  out  2  buffer occupancy (0..2), for debug/perf.

Behaviour:
- FIFO semantics:
  - dout is valid whenever !empty.
  - A pop asserted in cycle t removes the head at the clk edge ending t.
- Eligibility and grant:
  - Channel c is eligible when !resp_fifo_empty_i[c] && ch_en_i[c].
  - Grant = first eligible channel scanning ptr, ptr+1, ... modulo NUM_CH.
- Pop rule:
  - resp_fifo_read_o[grant] = 1 iff an eligible channel exists && occ != 2 && !rst_i.
  - Depends only on registered state and FIFO flags, never on rsp_rdy_i.
- Pointer update:
  - On a pop, ptr <= (grant+1) mod NUM_CH.
  - No pop → ptr holds.
  - NUM_CH=1: ptr is constantly 0.
- Buffer states, with push = any pop this cycle and take = rsp_val_o && rsp_rdy_i:
  - EMPTY (occ 0):
    - push → ONE; main <= {head, grant}.
  - ONE (occ 1):
    - push && take → ONE; main <= new.
    - push && !take → FULL; skid <= new.
    - !push && take → EMPTY.
    - otherwise hold.
  - FULL (occ 2): push is impossible.
    - take → ONE; main <= skid.
    - otherwise hold.
- rsp_val_o = (occ != 0); rsp_data_o/rsp_ch_o = main register.
- Output stability: while rsp_val_o && !rsp_rdy_i, rsp_data_o and rsp_ch_o hold.
- Latency: FIFO becomes non-empty in cycle t with occ<2 → rsp_val_o in cycle t+1.
- Throughput: with rsp_rdy_i held high and an eligible channel every cycle, one response per cycle, continuous.
- Ordering:
  - Per-channel order is preserved.
  - Across channels, output order equals grant order.
- ch_en_i deasserted mid-stream:
  - Entries already buffered are still delivered.
  - The channel is simply not granted again.
- All channels disabled or empty: no pops; buffer drains normally.
- Reset (also mid-operation), while rst_i is high:
  - occ=0, rsp_val_o=0, rsp_data_o=0, rsp_ch_o=0, ptr=0, resp_fifo_read_o=0.
  - Buffered entries are discarded; FIFOs are not touched.
  - First pop possible in the cycle after rst_i deasserts.
- X-safety: rsp_data_o is never driven from an unselected dout.

Test Plan:
- Single channel, NUM_CH=4, ch0 holds 0xA1, 0xA2, 0xA3; rsp_rdy_i=1 → outputs A1, A2, A3 on consecutive cycles starting 1 cycle after first non-empty; rsp_ch_o=0; occ_o never exceeds 1.
- Round robin: ch0..ch3 each hold 2 words (0xC0n tagged), ptr=0, rdy=1 → channel sequence 0,1,2,3,0,1,2,3; 8 responses in 8 consecutive cycles.
- Backpressure: ch1 holds 0x11, 0x12, 0x13; rsp_rdy_i=0 for 5 cycles, then 1 → exactly 2 pops occur, occ_o=2, rsp_data_o=0x11 stable throughout the stall. After release: 0x11, 0x12, 0x13 in consecutive cycles, no loss or duplication.
- Mask: all four channels full, ch_en_i=4'b0101 → only channels 0 and 2 are granted, alternating. Set ch_en_i=4'b1111 mid-stream → ptr continues from its stored value.
- Reset mid-operation: occ_o=2 and ch2 non-empty, assert rst_i for 1 cycle → next cycle rsp_val_o=0, occ_o=0, no pops during reset. Resumes from ch0-first scan; ch2's remaining data is delivered.
- NUM_CH=1 build: random empty/rdy traffic for 1000 cycles vs scoreboard → exact in-order match; resp_fifo_read_o never asserted while empty or while occ_o=2.
